accel_spi_reader: RTL and testbench

SPI master that configures an ADXL362 3-axis accelerometer and periodically burst-reads its X and Y acceleration registers. It presents the results as two 16-bit words, `ax` and `ay`, to the downstream ball-physics stage. That stage samples them on its own 60 Hz tick, so both words always change together in a single clk cycle. The block runs on the 100 MHz system clock and drives the accelerometer pins directly.

---
 rtl/accel_spi_reader.sv | 111 +++++++++++
 tb/tb_accel_spi_reader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/accel_spi_reader.sv
// accel_spi_reader: SPI mode-0 master that enables ADXL362 measurement mode,
// then periodically burst-reads XDATA/YDATA into atomically updated outputs.
module accel_spi_reader #(
  parameter int SCLK_HALF      = 50,
  parameter int STARTUP_CYCLES = 500_000,
  parameter int SAMPLE_DIV     = 1_666_667
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [15:0] ax,
  output logic [15:0] ay,
  output logic        data_valid
);
  typedef enum logic [2:0] {ST_STARTUP, ST_CFG, ST_WAIT, ST_READ, ST_UPDATE} state_t;
  state_t      r_state, w_state_nx;
  logic [31:0] r_tmr, w_tmr_nx;
  logic [31:0] r_smp, w_smp_nx;
  logic [15:0] r_div, w_div_nx;
  logic [6:0]  r_slot, w_slot_nx;
  logic [47:0] r_tx, w_tx_nx;
  logic [31:0] r_rx;
  logic        r_miso_s1, r_miso_s2;
  logic        w_txn, w_txn_nx, w_last_div, w_fall, w_done;
  logic        w_sclk_nx, w_mosi_nx;
  logic [6:0]  w_last_slot;
  // A transaction is 16N+2 slots of H cycles: one idle lead slot, 16N SCLK
  // half-periods starting high, and one trailing hold slot.
  assign w_txn       = r_state == ST_CFG || r_state == ST_READ;
  assign w_last_slot = r_state == ST_READ ? 7'd97 : 7'd49;
  assign w_last_div  = r_div == 16'(SCLK_HALF - 1);
  assign w_fall      = w_txn && w_last_div && r_slot[0] && r_slot != w_last_slot;
  assign w_done      = w_txn && w_last_div && r_slot == w_last_slot;
  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr;
    w_smp_nx   = r_smp + 32'd1;
    w_div_nx   = w_txn && !w_last_div ? r_div + 16'd1 : 16'd0;
    w_slot_nx  = w_txn && w_last_div ? r_slot + 7'd1 : r_slot;
    w_tx_nx    = w_fall ? {r_tx[46:0], 1'b0} : r_tx;
    case (r_state)
      ST_STARTUP: begin
        w_tmr_nx = r_tmr + 32'd1;
        if (r_tmr == 32'(STARTUP_CYCLES - 1)) begin
          w_state_nx = ST_CFG;
          w_slot_nx  = '0;
          w_tx_nx    = {24'h0A2D02, 24'h0};
        end
      end
      ST_CFG: begin
        if (w_done) begin
          w_state_nx = ST_WAIT;
          w_smp_nx   = '0;
        end
      end
      ST_WAIT: begin
        if (r_smp == 32'(SAMPLE_DIV - 1)) begin
          w_state_nx = ST_READ;
          w_smp_nx   = '0;
          w_slot_nx  = '0;
          w_tx_nx    = {8'h0B, 8'h0E, 32'h0};
        end
      end
      ST_READ:   w_state_nx = w_done ? ST_UPDATE : ST_READ;
      ST_UPDATE: w_state_nx = ST_WAIT;
      default:   w_state_nx = ST_STARTUP;
    endcase
  end
  // Pins are registered from the next-state decode so they never glitch.
  assign w_txn_nx  = w_state_nx == ST_CFG || w_state_nx == ST_READ;
  assign w_sclk_nx = w_txn_nx && w_slot_nx[0] && w_slot_nx < (w_state_nx == ST_READ ? 7'd96 : 7'd48);
  assign w_mosi_nx = w_txn_nx && w_tx_nx[47];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_STARTUP;
      r_tmr      <= '0;
      r_smp      <= '0;
      r_div      <= '0;
      r_slot     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_miso_s1  <= 1'b0;
      r_miso_s2  <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      ax         <= '0;
      ay         <= '0;
      data_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_tmr      <= w_tmr_nx;
      r_smp      <= w_smp_nx;
      r_div      <= w_div_nx;
      r_slot     <= w_slot_nx;
      r_tx       <= w_tx_nx;
      r_miso_s1  <= miso;
      r_miso_s2  <= r_miso_s1;
      r_rx       <= w_fall ? {r_rx[30:0], r_miso_s2} : r_rx;
      sclk       <= w_sclk_nx;
      mosi       <= w_mosi_nx;
      cs_n       <= !w_txn_nx;
      ax         <= r_state == ST_UPDATE ? {r_rx[23:16], r_rx[31:24]} : ax;
      ay         <= r_state == ST_UPDATE ? {r_rx[7:0], r_rx[15:8]} : ay;
      data_valid <= r_state == ST_UPDATE;
    end
  end
endmodule

// File: tb/tb_accel_spi_reader.sv
// tb_accel_spi_reader: mode-0 SPI slave with random sensor data and a
// transaction-level expectation model for pins, cadence and outputs.
module tb_accel_spi_reader;
  localparam int H = 4, SC = 100, SD = 2000;
  logic clk = 0, rst = 1, miso = 0;
  logic sclk, mosi, cs_n, data_valid;
  logic [15:0] ax, ay;
  accel_spi_reader #(.SCLK_HALF(H), .STARTUP_CYCLES(SC), .SAMPLE_DIV(SD)) dut (
    .clk(clk), .rst(rst), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .ax(ax), .ay(ay), .data_valid(data_valid));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  logic p_cs = 1, p_sclk = 0, p_mosi = 0;
  logic [47:0] cap_bits, resp_bits;
  logic [15:0] exp_ax = 0, exp_ay = 0, nxt_ax, nxt_ay;
  int txn_idx = 0, rel_t = 0, fall_t = 0, cfg_rise = 0, prev_read_fall = 0;
  int rises = 0, falls = 0, mosi_bad = 0, dv_due = -1, nreads = 0, dv_seen = 0, cfg_cnt = 0;
  // Monitor, slave and expectation model; samples 1 time unit after each edge.
  initial begin
    logic r;
    int n;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ax", ax, 0);
        chk("rst_ay", ay, 0);
        chk("rst_dv", data_valid, 0);
        txn_idx = 0; dv_due = -1; exp_ax = 0; exp_ay = 0; rel_t = cyc; miso = 0;
      end else begin
        chk("data_valid", data_valid, cyc == dv_due);
        if (cyc == dv_due) begin
          exp_ax = nxt_ax; exp_ay = nxt_ay; dv_seen++;
        end
        chk("ax", ax, exp_ax);
        chk("ay", ay, exp_ay);
        if (cs_n) begin
          chk("idle_sclk", sclk, 0);
          chk("idle_mosi", mosi, 0);
        end
        if (p_cs && !cs_n) begin
          fall_t = cyc; rises = 0; falls = 0; mosi_bad = 0; cap_bits = 0;
          resp_bits = {16'($urandom), 32'($urandom)};
          if (txn_idx > 0 && nreads == 0) resp_bits[31:0] = 32'h3402F007;
          if (txn_idx > 0 && nreads == 1) resp_bits[31:0] = 32'h0CFF00F8;
          miso = resp_bits[47];
          if (txn_idx == 0) chk("startup_len", cyc - rel_t, SC);
          else if (txn_idx == 1) chk("first_read_gap", cyc - cfg_rise, SD);
          else chk("read_spacing", cyc - prev_read_fall, SD);
          if (txn_idx > 0) prev_read_fall = cyc;
        end
        if (!p_cs && !cs_n) begin
          if (!p_sclk && sclk) begin
            rises++;
            cap_bits = {cap_bits[46:0], mosi};
          end
          if (mosi != p_mosi && !(p_sclk && !sclk)) mosi_bad++;
          if (p_sclk && !sclk) begin
            falls++;
            miso = falls < 48 ? resp_bits[47 - falls] : 1'b0;
          end
        end
        if (!p_cs && cs_n) begin
          n = txn_idx == 0 ? 3 : 6;
          miso = 0;
          chk("cs_low_len", cyc - fall_t, (16 * n + 2) * H);
          chk("sclk_rises", rises, 8 * n);
          chk("mosi_stable", mosi_bad, 0);
          if (txn_idx == 0) begin
            chk("cfg_bytes", cap_bits, 48'h0A2D02);
            cfg_rise = cyc; cfg_cnt++;
          end else begin
            chk("read_bytes", cap_bits, 48'h0B0E_0000_0000);
            dv_due = cyc + 1;
            nxt_ax = {resp_bits[23:16], resp_bits[31:24]};
            nxt_ay = {resp_bits[7:0], resp_bits[15:8]};
            nreads++;
          end
          txn_idx++;
        end
      end
      p_cs = cs_n; p_sclk = sclk; p_mosi = mosi;
    end
  end
  task automatic wait_dv(input int n);
    for (int g = 0; g < 30000 && dv_seen < n; g++) begin
      @(posedge clk);
      #2;
    end
    chk("dv_count_reached", dv_seen, n);
  endtask
  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 0;
    wait_dv(1);
    chk("ax_pos", ax, 16'h0234);
    chk("ay_pos", ay, 16'h07F0);
    chk("model_ax_pos", exp_ax, 16'h0234);
    wait_dv(2);
    chk("ax_neg", ax, 16'hFF0C);
    chk("ay_neg", ay, 16'hF800);
    chk("model_ay_neg", exp_ay, 16'hF800);
    wait_dv(4);
    for (int g = 0; g < 5000 && !(txn_idx >= 1 && !cs_n && rises == 28); g++) begin
      @(posedge clk);
      #2;
    end
    chk("reach_byte4", rises, 28);
    @(negedge clk) rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    wait_dv(6);
    chk("cfg_count", cfg_cnt, 2);
    chk("read_count", nreads, 6);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
